div_seq: RTL and testbench
==========================

DIV_SEQ -- requirements
Module: div_seq

Interface
REQ-001 The block SHALL have parameter N_BITS, default 32, meaning the operand and result width.
REQ-002 The block SHALL have parameter DIV_LAT, default 33, meaning the cycles from a div_start pulse until div_hi/div_lo are valid (N_BITS+1).
REQ-003 The block SHALL have port clk  input  1  the single rising-edge clock.
REQ-004 The block SHALL have port reset  input  1  asynchronous, active-low reset (asserted at 0).
REQ-005 The block SHALL have port start  input  1  divide request from the control unit, sampled in IDLE only.
REQ-006 The block SHALL have ports op_a, op_b  input  N_BITS  dividend and divisor, sampled with start.
REQ-007 The block SHALL have port flush  input  1  aborts any divide in progress.
REQ-008 The block SHALL have ports mthi, mtlo  input  1 each, and wdata  input  N_BITS  direct HI/LO write (MTHI/MTLO).
REQ-009 The block SHALL have ports div_a, div_b  output  N_BITS  operands to the divider srcA/srcB.
REQ-010 The block SHALL have port div_start  output  1  one-cycle start pulse to the divider divCtrl.
REQ-011 The block SHALL have ports div_hi, div_lo  input  N_BITS, and div_zero  input  1  divider results and divide-by-zero flag.
REQ-012 The block SHALL have ports hi, lo  output  N_BITS  architectural HI (remainder) and LO (quotient).
REQ-013 The block SHALL have ports busy, done, exc_div0  output  1 each  stall flag, commit pulse, divide-by-zero exception pulse.

Function
REQ-014 The block SHALL implement states IDLE, ISSUE, WAIT, COMMIT; busy SHALL be 1 in ISSUE, WAIT and COMMIT, 0 in IDLE.
REQ-015 In IDLE, start=1 with op_b!=0 SHALL latch op_a/op_b into div_a/div_b and move to ISSUE.
REQ-016 In IDLE, start=1 with op_b==0 SHALL stay in IDLE, pulse exc_div0 for exactly one cycle on the next clock, and leave hi/lo unchanged.
REQ-017 In ISSUE, div_start SHALL be 1 for exactly one cycle, a cycle counter SHALL load DIV_LAT-1, and the next state SHALL be WAIT.
REQ-018 In WAIT, the counter SHALL decrement each cycle; on reaching 0 the next state SHALL be COMMIT, giving DIV_LAT cycles from the div_start cycle to the COMMIT cycle.
REQ-019 In WAIT, div_zero=1 SHALL abort to IDLE, pulse exc_div0 for one cycle, and commit nothing.
REQ-020 In COMMIT, hi<=div_hi and lo<=div_lo SHALL be written, done SHALL be 1 for that one cycle, and the next state SHALL be IDLE.
REQ-021 div_a/div_b SHALL stay constant from the ISSUE cycle through the COMMIT cycle.
REQ-022 start SHALL be ignored while busy=1.
REQ-023 flush=1 in ISSUE/WAIT/COMMIT SHALL return to IDLE on the next clock with no hi/lo write and no done/exc_div0; in IDLE, flush SHALL also cancel a coincident start.
REQ-024 mthi/mtlo SHALL write wdata to hi/lo on the clock edge only when busy=0; while busy=1 they SHALL be ignored.
REQ-025 mthi and start in the same IDLE cycle SHALL both take effect: hi takes wdata now and is overwritten at COMMIT.
REQ-026 done and exc_div0 SHALL never both be 1 in the same cycle.
REQ-027 The block SHALL perform no arithmetic on the operands; signedness is owned by the divider.

Reset
REQ-028 reset=0 SHALL immediately force state=IDLE, counter=0, and busy, done, exc_div0, div_start=0, and hi, lo, div_a, div_b=0, regardless of clk.
REQ-029 reset asserted mid-divide SHALL discard the operation; after release the block SHALL accept a new start on the first IDLE cycle.

Verification
REQ-030 With the real divider attached, reset, then start with op_a=-25 (0xFFFFFFE7), op_b=6 -> div_start pulses once, busy=1 for DIV_LAT+2 cycles, done pulses, lo=0xFFFFFFFC (-4), hi=0xFFFFFFFF (-1).
REQ-031 start with op_a=190, op_b=13 -> done after DIV_LAT+2 cycles from start, lo=14, hi=8; a second start pulsed mid-WAIT is ignored.
REQ-032 start with op_a=7, op_b=0 -> exc_div0 pulses one cycle later, no div_start, busy stays 0, hi/lo keep prior values.
REQ-033 Start 190/13, assert flush 10 cycles later -> busy=0 next cycle, no done, hi/lo unchanged; mthi with wdata=0x1234 then sets hi=0x1234.
REQ-034 Start 190/13, drive reset=0 mid-WAIT between clock edges -> all outputs 0 immediately; after release, 190/13 again completes with lo=14, hi=8.
REQ-035 mtlo with wdata=0xAA while busy=1 -> lo unaffected until COMMIT writes the quotient.

Source files
------------

// File: rtl/div_seq_if.sv
// Bundle of the control-unit, divider-side and HI/LO signals of the sequential divide controller.
// The slave modport belongs to div_seq; the master modport is for whatever drives and observes it.
interface div_seq_if #(
  parameter int N_BITS = 32
);
  // control unit requests
  logic              start;
  logic [N_BITS-1:0] op_a;
  logic [N_BITS-1:0] op_b;
  logic              flush;
  logic              mthi;
  logic              mtlo;
  logic [N_BITS-1:0] wdata;

  // divider datapath
  logic [N_BITS-1:0] div_a;
  logic [N_BITS-1:0] div_b;
  logic              div_start;
  logic [N_BITS-1:0] div_hi;
  logic [N_BITS-1:0] div_lo;
  logic              div_zero;

  // architectural state and status
  logic [N_BITS-1:0] hi;
  logic [N_BITS-1:0] lo;
  logic              busy;
  logic              done;
  logic              exc_div0;

  modport slave (
    input  start, op_a, op_b, flush, mthi, mtlo, wdata,
    input  div_hi, div_lo, div_zero,
    output div_a, div_b, div_start,
    output hi, lo, busy, done, exc_div0
  );

  modport master (
    output start, op_a, op_b, flush, mthi, mtlo, wdata,
    output div_hi, div_lo, div_zero,
    input  div_a, div_b, div_start,
    input  hi, lo, busy, done, exc_div0
  );
endinterface

// File: rtl/div_seq.sv
// Sequencer around a multi-cycle divider: issues the operands, waits out the divider latency,
// commits remainder/quotient into HI/LO, and handles divide-by-zero, flush and MTHI/MTLO.
module div_seq #(
  parameter int N_BITS  = 32,
  parameter int DIV_LAT = 33
) (
  input logic      clk,
  input logic      reset,
  div_seq_if.slave bus
);

  localparam int CNT_W = $clog2(DIV_LAT + 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ISSUE,
    ST_WAIT,
    ST_COMMIT
  } state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [N_BITS-1:0] div_a_q, div_a_d;
  logic [N_BITS-1:0] div_b_q, div_b_d;
  logic [N_BITS-1:0] hi_q, hi_d;
  logic [N_BITS-1:0] lo_q, lo_d;
  logic              exc_q, exc_d;
  logic              busy;

  assign busy = (state_q != ST_IDLE);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      div_a_q <= '0;
      div_b_q <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
      exc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      div_a_q <= div_a_d;
      div_b_q <= div_b_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      exc_q   <= exc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    div_a_d = div_a_q;
    div_b_d = div_b_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    exc_d   = 1'b0;

    // Direct writes land only while idle; a commit later in the same divide overrides them.
    if (!busy) begin
      if (bus.mthi) hi_d = bus.wdata;
      if (bus.mtlo) lo_d = bus.wdata;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start && !bus.flush) begin
          if (bus.op_b == '0) begin
            exc_d = 1'b1;
          end else begin
            div_a_d = bus.op_a;
            div_b_d = bus.op_b;
            state_d = ST_ISSUE;
          end
        end
      end

      ST_ISSUE: begin
        if (bus.flush) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d   = CNT_W'(DIV_LAT - 1);
          state_d = ST_WAIT;
        end
      end

      ST_WAIT: begin
        if (bus.flush) begin
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else if (bus.div_zero) begin
          cnt_d   = '0;
          exc_d   = 1'b1;
          state_d = ST_IDLE;
        end else if (cnt_q == '0) begin
          state_d = ST_COMMIT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end

      ST_COMMIT: begin
        state_d = ST_IDLE;
        if (!bus.flush) begin
          hi_d = bus.div_hi;
          lo_d = bus.div_lo;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.div_a     = div_a_q;
  assign bus.div_b     = div_b_q;
  assign bus.div_start = (state_q == ST_ISSUE) && !bus.flush;
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.busy      = busy;
  assign bus.done      = (state_q == ST_COMMIT) && !bus.flush;
  assign bus.exc_div0  = exc_q;

  // exc_div0 is only ever seen in IDLE, so it can never coincide with a commit
  a_done_exc_exclusive : assert property (@(posedge clk) disable iff (!reset)
    !(bus.done && bus.exc_div0));

endmodule

// File: tb/tb_div_seq.sv
// Directed bench for div_seq with a behavioural divider whose results only become valid
// DIV_LAT cycles after div_start.
module tb_div_seq;

  localparam int N_BITS   = 32;
  localparam int DIV_LAT  = 33;
  localparam int BUSY_EXP = 35;   // ISSUE + 33 WAIT + COMMIT
  localparam int MAX_CYC  = 200;

  logic clk;
  logic reset;
  int   total;
  int   bad;

  div_seq_if #(.N_BITS(N_BITS)) bus ();

  div_seq #(.N_BITS(N_BITS), .DIV_LAT(DIV_LAT)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // divider model: garbage until DIV_LAT cycles after div_start, then held results
  int          dv_cnt;
  logic        dv_arm;
  logic [31:0] dv_a, dv_b;
  logic [31:0] q_v, r_v;

  initial begin
    dv_cnt = 0;
    dv_arm = 1'b0;
    dv_a   = '0;
    dv_b   = '0;
  end

  always @(posedge clk) begin
    if (bus.div_start) begin
      dv_cnt <= DIV_LAT - 1;
      dv_arm <= 1'b1;
      dv_a   <= bus.div_a;
      dv_b   <= bus.div_b;
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
    end
  end

  always_comb begin
    q_v = 32'hDEADBEEF;
    r_v = 32'hBADC0FFE;
    if (dv_arm && dv_cnt == 0 && dv_b != 32'd0) begin
      q_v = $signed(dv_a) / $signed(dv_b);
      r_v = $signed(dv_a) % $signed(dv_b);
    end
  end

  assign bus.div_lo = q_v;
  assign bus.div_hi = r_v;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b);
    bus.op_a  = a;
    bus.op_b  = b;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  // Runs from the ISSUE cycle until busy drops, injecting pokes at given busy-cycle indices.
  task automatic observe(input int poke_at, input int flush_at, input int dz_at,
                         input int mt_at, input logic [31:0] mt_data,
                         output int bc, output int ds, output int dn, output int ex,
                         output int done_at, output bit hold_ok, output bit tmo);
    logic [31:0] a0, b0, h0, l0;
    int c;
    a0 = bus.div_a; b0 = bus.div_b; h0 = bus.hi; l0 = bus.lo;
    bc = 0; ds = 0; dn = 0; ex = 0; done_at = -1; hold_ok = 1'b1; tmo = 1'b0;
    bus.mthi = 1'b0;
    c = 0;
    while (bus.busy && c < MAX_CYC) begin
      bus.start    = (c == poke_at);
      bus.flush    = (c == flush_at);
      bus.div_zero = (c == dz_at);
      bus.mtlo     = (c == mt_at);
      if (c == poke_at) begin
        bus.op_a = 32'd100;
        bus.op_b = 32'd3;
      end
      if (c == mt_at) bus.wdata = mt_data;
      #1;
      bc++;
      if (bus.div_start) ds++;
      if (bus.done) begin
        dn++;
        done_at = c;
      end
      if (bus.exc_div0) ex++;
      if (bus.div_a !== a0 || bus.div_b !== b0 || bus.hi !== h0 || bus.lo !== l0) hold_ok = 1'b0;
      @(posedge clk);
      #1;
      c++;
    end
    bus.start = 1'b0; bus.flush = 1'b0; bus.div_zero = 1'b0; bus.mtlo = 1'b0;
    if (c >= MAX_CYC) tmo = 1'b1;
    if (bus.exc_div0) ex++;
  endtask

  task automatic test_reset();
    total++; if (bus.busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", bus.busy); end
    total++; if (bus.done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", bus.done); end
    total++; if (bus.exc_div0 !== 1'b0) begin bad++; $display("FAIL reset_exc got=%b exp=0", bus.exc_div0); end
    total++; if (bus.div_start !== 1'b0) begin bad++; $display("FAIL reset_div_start got=%b exp=0", bus.div_start); end
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0) begin bad++; $display("FAIL reset_hilo got=%h/%h exp=0/0", bus.hi, bus.lo); end
    total++; if (bus.div_a !== 32'd0 || bus.div_b !== 32'd0) begin bad++; $display("FAIL reset_divab got=%h/%h exp=0/0", bus.div_a, bus.div_b); end
    $display("reset: busy=%b hi=%h lo=%h", bus.busy, bus.hi, bus.lo);
    reset = 1'b1;
    tick();
  endtask

  task automatic test_signed_div();
    int bc, ds, dn, ex, da; bit hold, tmo;
    issue(32'hFFFFFFE7, 32'd6);
    total++; if (bus.div_a !== 32'hFFFFFFE7 || bus.div_b !== 32'd6) begin bad++; $display("FAIL signed_latch got=%h/%h exp=ffffffe7/00000006", bus.div_a, bus.div_b); end
    observe(-1, -1, -1, -1, 32'h0, bc, ds, dn, ex, da, hold, tmo);
    total++; if (tmo) begin bad++; $display("FAIL signed_timeout got=1 exp=0"); end
    total++; if (bc !== BUSY_EXP) begin bad++; $display("FAIL signed_busy_cycles got=%0d exp=%0d", bc, BUSY_EXP); end
    total++; if (ds !== 1) begin bad++; $display("FAIL signed_div_start got=%0d exp=1", ds); end
    total++; if (dn !== 1 || da !== BUSY_EXP - 1) begin bad++; $display("FAIL signed_done got=%0d@%0d exp=1@%0d", dn, da, BUSY_EXP - 1); end
    total++; if (ex !== 0) begin bad++; $display("FAIL signed_exc got=%0d exp=0", ex); end
    total++; if (!hold) begin bad++; $display("FAIL signed_hold got=0 exp=1"); end
    total++; if (bus.lo !== 32'hFFFFFFFC || bus.hi !== 32'hFFFFFFFF) begin bad++; $display("FAIL signed_result got=%h/%h exp=fffffffc/ffffffff", bus.lo, bus.hi); end
    $display("signed div: busy_cycles=%0d lo=%h hi=%h", bc, bus.lo, bus.hi);
  endtask

  task automatic test_ignore_start();
    int bc, ds, dn, ex, da; bit hold, tmo;
    issue(32'd190, 32'd13);
    observe(15, -1, -1, -1, 32'h0, bc, ds, dn, ex, da, hold, tmo);
    total++; if (tmo || bc !== BUSY_EXP) begin bad++; $display("FAIL ignore_busy_cycles got=%0d exp=%0d", bc, BUSY_EXP); end
    total++; if (ds !== 1 || dn !== 1) begin bad++; $display("FAIL ignore_pulses got=ds%0d/dn%0d exp=ds1/dn1", ds, dn); end
    total++; if (!hold) begin bad++; $display("FAIL ignore_hold got=0 exp=1"); end
    total++; if (bus.lo !== 32'd14 || bus.hi !== 32'd8) begin bad++; $display("FAIL ignore_result got=%0d/%0d exp=14/8", bus.lo, bus.hi); end
    tick(); tick();
    total++; if (bus.busy !== 1'b0 || bus.div_a !== 32'd190) begin bad++; $display("FAIL ignore_no_restart got=busy%b/a%0d exp=busy0/a190", bus.busy, bus.div_a); end
    $display("ignored start: lo=%0d hi=%0d busy=%b", bus.lo, bus.hi, bus.busy);
  endtask

  task automatic test_div_by_zero();
    issue(32'd7, 32'd0);
    total++; if (bus.exc_div0 !== 1'b1) begin bad++; $display("FAIL div0_exc got=%b exp=1", bus.exc_div0); end
    total++; if (bus.busy !== 1'b0 || bus.div_start !== 1'b0) begin bad++; $display("FAIL div0_idle got=busy%b/ds%b exp=0/0", bus.busy, bus.div_start); end
    tick();
    total++; if (bus.exc_div0 !== 1'b0) begin bad++; $display("FAIL div0_exc_width got=%b exp=0", bus.exc_div0); end
    total++; if (bus.lo !== 32'd14 || bus.hi !== 32'd8) begin bad++; $display("FAIL div0_hilo got=%0d/%0d exp=14/8", bus.lo, bus.hi); end
    $display("div by zero: busy=%b lo=%0d hi=%0d", bus.busy, bus.lo, bus.hi);
  endtask

  task automatic test_flush();
    int bc, ds, dn, ex, da; bit hold, tmo;
    bus.mthi = 1'b1; bus.wdata = 32'h11; tick();
    bus.mthi = 1'b0; bus.mtlo = 1'b1; bus.wdata = 32'h22; tick();
    bus.mtlo = 1'b0;
    total++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin bad++; $display("FAIL mt_idle got=%h/%h exp=11/22", bus.hi, bus.lo); end
    issue(32'd190, 32'd13);
    observe(-1, 10, -1, -1, 32'h0, bc, ds, dn, ex, da, hold, tmo);
    total++; if (tmo || bc !== 11) begin bad++; $display("FAIL flush_busy_cycles got=%0d exp=11", bc); end
    total++; if (dn !== 0 || ex !== 0) begin bad++; $display("FAIL flush_pulses got=dn%0d/ex%0d exp=0/0", dn, ex); end
    total++; if (bus.hi !== 32'h11 || bus.lo !== 32'h22) begin bad++; $display("FAIL flush_hilo got=%h/%h exp=11/22", bus.hi, bus.lo); end
    bus.mthi = 1'b1; bus.wdata = 32'h1234; tick();
    bus.mthi = 1'b0;
    total++; if (bus.hi !== 32'h1234) begin bad++; $display("FAIL flush_mthi got=%h exp=1234", bus.hi); end
    bus.flush = 1'b1;
    issue(32'd190, 32'd13);
    bus.flush = 1'b0;
    total++; if (bus.busy !== 1'b0 || bus.div_start !== 1'b0) begin bad++; $display("FAIL flush_idle_start got=busy%b/ds%b exp=0/0", bus.busy, bus.div_start); end
    $display("flush: busy_cycles=%0d hi=%h lo=%h", bc, bus.hi, bus.lo);
  endtask

  task automatic test_div_zero_abort();
    int bc, ds, dn, ex, da; bit hold, tmo;
    issue(32'd190, 32'd13);
    observe(-1, -1, 5, -1, 32'h0, bc, ds, dn, ex, da, hold, tmo);
    total++; if (tmo || bc !== 6) begin bad++; $display("FAIL abort_busy_cycles got=%0d exp=6", bc); end
    total++; if (dn !== 0 || ex !== 1) begin bad++; $display("FAIL abort_pulses got=dn%0d/ex%0d exp=0/1", dn, ex); end
    total++; if (bus.hi !== 32'h1234 || bus.lo !== 32'h22) begin bad++; $display("FAIL abort_hilo got=%h/%h exp=1234/22", bus.hi, bus.lo); end
    tick();
    total++; if (bus.exc_div0 !== 1'b0) begin bad++; $display("FAIL abort_exc_width got=%b exp=0", bus.exc_div0); end
    $display("div_zero abort: busy_cycles=%0d exc=%0d", bc, ex);
  endtask

  task automatic test_mtlo_busy();
    int bc, ds, dn, ex, da; bit hold, tmo;
    issue(32'd190, 32'd13);
    observe(-1, -1, -1, 5, 32'hAA, bc, ds, dn, ex, da, hold, tmo);
    total++; if (!hold) begin bad++; $display("FAIL mtlo_busy_hold got=0 exp=1"); end
    total++; if (bus.lo !== 32'd14 || bus.hi !== 32'd8) begin bad++; $display("FAIL mtlo_busy_result got=%0d/%0d exp=14/8", bus.lo, bus.hi); end
    $display("mtlo while busy: lo=%0d hi=%0d", bus.lo, bus.hi);
  endtask

  task automatic test_mthi_with_start();
    int bc, ds, dn, ex, da; bit hold, tmo;
    bus.mthi = 1'b1; bus.wdata = 32'h5555;
    issue(32'd190, 32'd13);
    bus.mthi = 1'b0;
    total++; if (bus.hi !== 32'h5555 || bus.busy !== 1'b1) begin bad++; $display("FAIL mthi_start got=hi%h/busy%b exp=5555/1", bus.hi, bus.busy); end
    observe(-1, -1, -1, -1, 32'h0, bc, ds, dn, ex, da, hold, tmo);
    total++; if (bus.hi !== 32'd8 || bus.lo !== 32'd14) begin bad++; $display("FAIL mthi_start_commit got=%0d/%0d exp=8/14", bus.hi, bus.lo); end
    $display("mthi with start: hi=%0d lo=%0d", bus.hi, bus.lo);
  endtask

  task automatic test_reset_mid();
    int bc, ds, dn, ex, da; bit hold, tmo;
    issue(32'd190, 32'd13);
    repeat (10) tick();
    #2;
    reset = 1'b0;
    #1;
    total++; if (bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.exc_div0 !== 1'b0 || bus.div_start !== 1'b0) begin bad++; $display("FAIL rstmid_flags got=%b%b%b%b exp=0000", bus.busy, bus.done, bus.exc_div0, bus.div_start); end
    total++; if (bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.div_a !== 32'd0 || bus.div_b !== 32'd0) begin bad++; $display("FAIL rstmid_data got=%h/%h/%h/%h exp=0", bus.hi, bus.lo, bus.div_a, bus.div_b); end
    #2;
    reset = 1'b1;
    tick();
    issue(32'd190, 32'd13);
    total++; if (bus.busy !== 1'b1) begin bad++; $display("FAIL rstmid_accept got=%b exp=1", bus.busy); end
    observe(-1, -1, -1, -1, 32'h0, bc, ds, dn, ex, da, hold, tmo);
    total++; if (tmo || bc !== BUSY_EXP || dn !== 1) begin bad++; $display("FAIL rstmid_rerun got=bc%0d/dn%0d exp=%0d/1", bc, dn, BUSY_EXP); end
    total++; if (bus.lo !== 32'd14 || bus.hi !== 32'd8) begin bad++; $display("FAIL rstmid_result got=%0d/%0d exp=14/8", bus.lo, bus.hi); end
    $display("reset mid-divide: rerun lo=%0d hi=%0d", bus.lo, bus.hi);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    reset = 1'b0;
    bus.start = 1'b0; bus.op_a = '0; bus.op_b = '0; bus.flush = 1'b0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0; bus.div_zero = 1'b0;
    #2;
    test_reset();
    test_signed_div();
    test_ignore_start();
    test_div_by_zero();
    test_flush();
    test_div_zero_abort();
    test_mtlo_busy();
    test_mthi_with_start();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
